cga_vram_arbiter: RTL and testbench
===================================

Name: cga_vram_arbiter

Overview:
- Shares the single 8-bit video RAM between the CGA display fetch path and CPU ISA memory cycles in the B8000 window.
- Display fetches always win. CPU accesses are queued into free sequencer slots and stretched with bus_rdy wait states, so no display fetch is lost ("no snow").
- A starvation timeout lets the CPU take a display slot if no free slot appears.
- Sits between the ISA bus decode and the cga/cga_sequencer RAM port; it owns ram_a, ram_we_l and the CPU read-data return.

Parameters:
- USE_BUS_WAIT, 1, 1 = drive bus_rdy wait states; 0 = bus_rdy tied 1, CPU accesses still arbitrated.
- MAX_WAIT, 6'd40, clk cycles in WAIT_SLOT before the CPU is forced onto the RAM.
- FB_BITS, 15, framebuffer address width (32K, Tandy).

Ports:
- clk  in  1  system clock (28.636 MHz)
- reset  in  1  synchronous, active-high
- disp_req  in  1  display owns the RAM this cycle (sequencer vram fetch slot)
- disp_addr  in  19  display RAM address
- cpu_cs  in  1  CPU address decodes to the framebuffer window
- bus_a  in  FB_BITS  CPU address
- bus_memr_l  in  1  ISA memory read strobe, asynchronous
- bus_memw_l  in  1  ISA memory write strobe, asynchronous
- bus_d  in  8  CPU write data
- bus_out  out  8  CPU read data
- bus_dir  out  1  high while returning read data
- bus_rdy  out  1  ISA ready, low = wait
- ram_a  out  19  RAM address
- ram_we_l  out  1  RAM write enable, active low
- ram_dout  out  8  RAM write data
- ram_d  in  8  RAM read data, valid 1 clk after address
- cpu_grant  out  1  RAM driven by CPU this cycle (debug/snow monitor)

Behaviour:
- Strobes pass through 2-flop synchronizers. A request is the falling edge of the synced strobe with cpu_cs=1. bus_a and bus_d are latched at the request edge.
- FSM states: IDLE, WAIT_SLOT, ACCESS, CAPTURE, HOLD.
  - IDLE -> WAIT_SLOT on request.
  - WAIT_SLOT -> ACCESS in the first cycle with disp_req=0, or when wait_cnt==MAX_WAIT (forced grant; display fetch in that cycle is overridden).
  - ACCESS, one cycle: cpu_grant=1; ram_a={4'h0, latched addr}; write: ram_we_l=0, ram_dout=latched data -> HOLD; read: -> CAPTURE.
  - CAPTURE: bus_out<=ram_d -> HOLD.
  - HOLD: remain until the synced strobe deasserts -> IDLE.
- Outside ACCESS: ram_a=disp_addr, ram_we_l=1, cpu_grant=0.
- wait_cnt: 6-bit, cleared on entry to WAIT_SLOT, saturates at MAX_WAIT.
- bus_rdy (USE_BUS_WAIT=1): combinational 0 when cpu_cs and either raw strobe is low and the FSM is not in HOLD; otherwise 1. This covers the synchronizer latency. Worst case low time is 2 sync + MAX_WAIT + 2 cycles.
- bus_dir = cpu_cs & ~bus_memr_l (raw). bus_out holds its last captured value.
- Read strobe lost while in WAIT_SLOT: abort to IDLE, no RAM access.
- Write strobe lost while in WAIT_SLOT: the write still completes (posted) and the FSM skips HOLD.
- A new request while not IDLE is ignored; the ISA protocol guarantees the strobe deasserts first.
- If both strobes are low at once, read has priority.
- Reset, any state: next cycle state=IDLE, ram_we_l=1, cpu_grant=0, bus_out=8'h00, wait_cnt=0, bus_rdy=1, synchronizers=1.

Test Plan:
- Write 8'hA5 to offset 15'h0123, disp_req=0 throughout -> ACCESS 3 clks after strobe fall; ram_a=19'h00123, ram_we_l=0 for exactly 1 clk; ram_dout=8'hA5.
- Read at 15'h0010 with RAM returning 8'h5A, disp_req high for 10 clks after request -> no cpu_grant during disp_req; bus_rdy low until HOLD; bus_out=8'h5A; bus_dir=1.
- disp_req held 1 for 60 clks, MAX_WAIT=40 -> forced ACCESS exactly 40 clks after WAIT_SLOT entry; cpu_grant=1 for 1 clk.
- Write strobe released during WAIT_SLOT -> write still performed at next free slot; FSM returns to IDLE, no HOLD.
- Read strobe released during WAIT_SLOT -> no RAM access, ram_we_l stays 1, back to IDLE.
- reset asserted in ACCESS of a write -> next clk ram_we_l=1, state IDLE, bus_rdy=1; USE_BUS_WAIT=0 build -> bus_rdy constantly 1.

Source files
------------

// File: rtl/cga_vram_arbiter.sv
// CGA video RAM arbiter: shares the 8-bit framebuffer RAM between display
// fetches (always first) and CPU ISA memory cycles. CPU cycles wait for a
// free sequencer slot and are held off with bus_rdy. A starvation timeout
// forces the CPU onto the RAM if the display never leaves a gap.
module cga_vram_arbiter #(
  parameter bit         USE_BUS_WAIT = 1'b1,
  parameter logic [5:0] MAX_WAIT     = 6'd40,
  parameter int         FB_BITS      = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               disp_req,
  input  logic [18:0]        disp_addr,
  input  logic               cpu_cs,
  input  logic [FB_BITS-1:0] bus_a,
  input  logic               bus_memr_l,
  input  logic               bus_memw_l,
  input  logic [7:0]         bus_d,
  output logic [7:0]         bus_out,
  output logic               bus_dir,
  output logic               bus_rdy,
  output logic [18:0]        ram_a,
  output logic               ram_we_l,
  output logic [7:0]         ram_dout,
  input  logic [7:0]         ram_d,
  output logic               cpu_grant
);

  localparam int PadBits = 19 - FB_BITS;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLOT,
    ACCESS,
    CAPTURE,
    HOLD
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic               r_memrS1;
  logic               r_memrS2;
  logic               r_memwS1;
  logic               r_memwS2;

  logic [FB_BITS-1:0] r_addr;
  logic [7:0]         r_data;
  logic               r_isRead;
  logic [5:0]         r_waitCnt;
  logic [7:0]         r_busOut;

  logic               w_readReq;
  logic               w_writeReq;
  logic               w_req;
  logic               w_waitDone;
  logic               w_strobeHigh;

  // Two-flop synchronizers for the asynchronous ISA strobes (idle high).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_memrS1 <= 1'b1;
      r_memrS2 <= 1'b1;
      r_memwS1 <= 1'b1;
      r_memwS2 <= 1'b1;
    end else begin
      r_memrS1 <= bus_memr_l;
      r_memrS2 <= r_memrS1;
      r_memwS1 <= bus_memw_l;
      r_memwS2 <= r_memwS1;
    end
  end

  // A request is the falling edge seen between the two synchronizer stages,
  // so the FSM reaches WAIT_SLOT two clocks after the raw strobe falls.
  assign w_readReq  = cpu_cs & ~r_memrS1 & r_memrS2;
  assign w_writeReq = cpu_cs & ~r_memwS1 & r_memwS2;
  assign w_req      = w_readReq | w_writeReq;

  // The current WAIT_SLOT cycle is the MAX_WAIT-th one: grant regardless.
  assign w_waitDone = ({1'b0, r_waitCnt} + 7'd1) >= {1'b0, MAX_WAIT};

  // Synchronized strobe of the cycle in progress has returned high.
  assign w_strobeHigh = r_isRead ? r_memrS2 : r_memwS2;

  // Latch address, data and direction when a request is accepted; read wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_data   <= 8'h00;
      r_isRead <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_addr   <= bus_a;
      r_data   <= bus_d;
      r_isRead <= w_readReq;
    end
  end

  // Starvation counter: cleared on entry to WAIT_SLOT, saturates at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_waitCnt <= 6'd0;
    end else if (r_state == IDLE && w_req) begin
      r_waitCnt <= 6'd0;
    end else if (r_state == WAIT_SLOT && r_waitCnt != MAX_WAIT) begin
      r_waitCnt <= r_waitCnt + 6'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a lost read aborts, a lost write is posted and skips HOLD.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) w_nextState = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (r_isRead && r_memrS2) w_nextState = IDLE;
        else if (!disp_req || w_waitDone) w_nextState = ACCESS;
      end
      ACCESS: begin
        if (r_isRead) w_nextState = CAPTURE;
        else if (r_memwS2) w_nextState = IDLE;
        else w_nextState = HOLD;
      end
      CAPTURE: begin
        w_nextState = HOLD;
      end
      HOLD: begin
        if (w_strobeHigh) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Read data return register, loaded one clock after the RAM address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busOut <= 8'h00;
    end else if (r_state == CAPTURE) begin
      r_busOut <= ram_d;
    end
  end

  // RAM port steering: the CPU owns the RAM only during ACCESS.
  always_comb begin
    cpu_grant = 1'b0;
    ram_a     = disp_addr;
    ram_we_l  = 1'b1;
    if (r_state == ACCESS) begin
      cpu_grant = 1'b1;
      ram_a     = {{PadBits{1'b0}}, r_addr};
      ram_we_l  = r_isRead;
    end
  end

  assign ram_dout = r_data;
  assign bus_out  = r_busOut;
  assign bus_dir  = cpu_cs & ~bus_memr_l;

  // Ready drops on the raw strobe to cover synchronizer latency; reset releases it.
  generate
    if (USE_BUS_WAIT) begin : g_busWait
      assign bus_rdy = ~(~reset & cpu_cs & (~bus_memr_l | ~bus_memw_l) &
                         (r_state != HOLD));
    end else begin : g_noBusWait
      assign bus_rdy = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed testbench for cga_vram_arbiter: writes, reads, display contention,
// forced grant after starvation, lost strobes, reset mid-access, no-wait build.
module tb_cga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispReq;
  logic [18:0] dispAddr;
  logic        cpuCs;
  logic [14:0] busA;
  logic        busMemrL;
  logic        busMemwL;
  logic [7:0]  busD;
  logic [7:0]  ramD;

  logic [7:0]  busOut;
  logic        busDir;
  logic        busRdy;
  logic [18:0] ramA;
  logic        ramWeL;
  logic [7:0]  ramDout;
  logic        cpuGrant;

  logic [7:0]  nwBusOut;
  logic        nwBusDir;
  logic        nwBusRdy;
  logic [18:0] nwRamA;
  logic        nwRamWeL;
  logic [7:0]  nwRamDout;
  logic        nwCpuGrant;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [18:0] DispA = 19'h71234;

  cga_vram_arbiter #(
    .USE_BUS_WAIT(1'b1),
    .MAX_WAIT    (6'd40),
    .FB_BITS     (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .disp_req  (dispReq),
    .disp_addr (dispAddr),
    .cpu_cs    (cpuCs),
    .bus_a     (busA),
    .bus_memr_l(busMemrL),
    .bus_memw_l(busMemwL),
    .bus_d     (busD),
    .bus_out   (busOut),
    .bus_dir   (busDir),
    .bus_rdy   (busRdy),
    .ram_a     (ramA),
    .ram_we_l  (ramWeL),
    .ram_dout  (ramDout),
    .ram_d     (ramD),
    .cpu_grant (cpuGrant)
  );

  cga_vram_arbiter #(
    .USE_BUS_WAIT(1'b0),
    .MAX_WAIT    (6'd40),
    .FB_BITS     (15)
  ) dutNoWait (
    .clk       (clk),
    .reset     (reset),
    .disp_req  (dispReq),
    .disp_addr (dispAddr),
    .cpu_cs    (cpuCs),
    .bus_a     (busA),
    .bus_memr_l(busMemrL),
    .bus_memw_l(busMemwL),
    .bus_d     (busD),
    .bus_out   (nwBusOut),
    .bus_dir   (nwBusDir),
    .bus_rdy   (nwBusRdy),
    .ram_a     (nwRamA),
    .ram_we_l  (nwRamWeL),
    .ram_dout  (nwRamDout),
    .ram_d     (ramD),
    .cpu_grant (nwCpuGrant)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic cs, input logic memrL,
                               input logic memwL, input logic dreq);
    cpuCs    = cs;
    busMemrL = memrL;
    busMemwL = memwL;
    dispReq  = dreq;
    #1;
  endtask

  // Linear sequence of directed steps.
  initial begin
    reset    = 1'b1;
    busA     = 15'h0000;
    busD     = 8'h00;
    ramD     = 8'h00;
    dispAddr = DispA;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(2);
    checkOutput("rst_we_l", ramWeL, 1);
    checkOutput("rst_grant", cpuGrant, 0);
    checkOutput("rst_bus_out", busOut, 8'h00);
    checkOutput("rst_rdy", busRdy, 1);
    checkOutput("rst_ram_a", ramA, DispA);
    checkOutput("rst_dir", busDir, 0);
    reset = 1'b0;
    tick();

    // Write A5 to 0123, display idle.
    $display("[TB] write with free slots");
    busA = 15'h0123;
    busD = 8'hA5;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("wr_rdy_low", busRdy, 0);
    checkOutput("nowait_rdy_wr", nwBusRdy, 1);
    checkOutput("wr_dir", busDir, 0);
    tick();
    checkOutput("wr_c1_grant", cpuGrant, 0);
    tick();
    checkOutput("wr_c2_grant", cpuGrant, 0);
    checkOutput("wr_c2_rdy", busRdy, 0);
    tick();
    checkOutput("wr_acc_grant", cpuGrant, 1);
    checkOutput("wr_acc_we_l", ramWeL, 0);
    checkOutput("wr_acc_ram_a", ramA, 19'h00123);
    checkOutput("wr_acc_dout", ramDout, 8'hA5);
    checkOutput("nowait_acc_grant", nwCpuGrant, 1);
    tick();
    checkOutput("wr_hold_we_l", ramWeL, 1);
    checkOutput("wr_hold_grant", cpuGrant, 0);
    checkOutput("wr_hold_ram_a", ramA, DispA);
    checkOutput("wr_hold_rdy", busRdy, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Read 0010 while the display holds the RAM for 10 clocks.
    $display("[TB] read behind display fetches");
    busA = 15'h0010;
    ramD = 8'h5A;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("rd_dir", busDir, 1);
    checkOutput("rd_rdy_low", busRdy, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("rd_disp_grant", cpuGrant, 0);
      checkOutput("rd_disp_rdy", busRdy, 0);
      checkOutput("nowait_rdy_rd", nwBusRdy, 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rd_acc_grant", cpuGrant, 1);
    checkOutput("rd_acc_ram_a", ramA, 19'h00010);
    checkOutput("rd_acc_we_l", ramWeL, 1);
    tick();
    checkOutput("rd_cap_grant", cpuGrant, 0);
    checkOutput("rd_cap_rdy", busRdy, 0);
    checkOutput("rd_cap_bus_out", busOut, 8'h00);
    tick();
    checkOutput("rd_hold_bus_out", busOut, 8'h5A);
    checkOutput("rd_hold_rdy", busRdy, 1);
    checkOutput("rd_hold_dir", busDir, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rd_rel_dir", busDir, 0);
    ticks(3);
    checkOutput("rd_keep_bus_out", busOut, 8'h5A);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Starved write to top address 7FFF: forced 40 clocks after WAIT_SLOT entry.
    $display("[TB] forced grant after starvation");
    busA = 15'h7FFF;
    busD = 8'h3C;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 41; i++) begin
      tick();
      checkOutput("force_wait_grant", cpuGrant, 0);
    end
    checkOutput("force_wait_rdy", busRdy, 0);
    tick();
    checkOutput("force_acc_grant", cpuGrant, 1);
    checkOutput("force_acc_ram_a", ramA, 19'h07FFF);
    checkOutput("force_acc_we_l", ramWeL, 0);
    checkOutput("force_acc_dout", ramDout, 8'h3C);
    tick();
    checkOutput("force_post_grant", cpuGrant, 0);
    checkOutput("force_post_we_l", ramWeL, 1);
    checkOutput("force_post_ram_a", ramA, DispA);
    checkOutput("force_post_rdy", busRdy, 1);
    ticks(17);
    checkOutput("force_hold_grant", cpuGrant, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Write strobe lost in WAIT_SLOT: posted write, then straight to IDLE.
    $display("[TB] posted write");
    busA = 15'h0200;
    busD = 8'h77;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    ticks(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("post_rdy_released", busRdy, 1);
    ticks(4);
    checkOutput("post_wait_grant", cpuGrant, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("post_acc_grant", cpuGrant, 1);
    checkOutput("post_acc_we_l", ramWeL, 0);
    checkOutput("post_acc_ram_a", ramA, 19'h00200);
    checkOutput("post_acc_dout", ramDout, 8'h77);
    // A read starting now is only accepted if the FSM went straight to IDLE.
    busA = 15'h0300;
    ramD = 8'hC3;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("post_rd_rdy", busRdy, 0);
    tick();
    checkOutput("post_idle_grant", cpuGrant, 0);
    checkOutput("post_idle_we_l", ramWeL, 1);
    ticks(2);
    checkOutput("post_nohold_grant", cpuGrant, 1);
    checkOutput("post_nohold_ram_a", ramA, 19'h00300);
    ticks(2);
    checkOutput("post_rd_bus_out", busOut, 8'hC3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    // Read strobe lost in WAIT_SLOT: aborted, no RAM access.
    $display("[TB] aborted read");
    busA = 15'h0400;
    ramD = 8'h11;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    ticks(2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("abort_dir", busDir, 0);
    ticks(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("abort_grant", cpuGrant, 0);
      checkOutput("abort_we_l", ramWeL, 1);
    end
    checkOutput("abort_bus_out", busOut, 8'hC3);

    // Reset during the ACCESS cycle of a write.
    $display("[TB] reset during access");
    busA = 15'h0555;
    busD = 8'h99;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(3);
    checkOutput("rstacc_we_l", ramWeL, 0);
    checkOutput("rstacc_grant", cpuGrant, 1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("rstacc_post_we_l", ramWeL, 1);
    checkOutput("rstacc_post_grant", cpuGrant, 0);
    checkOutput("rstacc_post_rdy", busRdy, 1);
    checkOutput("rstacc_post_bus_out", busOut, 8'h00);
    checkOutput("rstacc_post_ram_a", ramA, DispA);
    reset = 1'b0;
    busA  = 15'h0001;
    ramD  = 8'hE7;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rstacc_rd_rdy", busRdy, 0);
    checkOutput("nowait_rdy_rst", nwBusRdy, 1);
    ticks(2);
    checkOutput("rstacc_rd_c2_grant", cpuGrant, 0);
    tick();
    checkOutput("rstacc_rd_grant", cpuGrant, 1);
    checkOutput("rstacc_rd_ram_a", ramA, 19'h00001);
    ticks(2);
    checkOutput("rstacc_rd_bus_out", busOut, 8'hE7);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
